// File: rtl/j1_io_fabric.sv
// I/O interconnect between the J1 I/O port and NSLOTS 256-word peripheral pages,
// with a status page for fault capture and read/write access counters.
module j1_io_fabric #(
   parameter int          NSLOTS       = 4,
   parameter logic [7:0]  BASE_PAGE    = 8'h67,
   parameter logic [7:0]  STAT_PAGE    = 8'h7F,
   parameter logic [15:0] DEFAULT_DATA = 16'h0666,
   parameter bit          REG_RDATA    = 1'b0
) (
   input  logic                   sys_clk_i,
   input  logic                   sys_rst_i,
   input  logic                   j1_io_rd,
   input  logic                   j1_io_wr,
   input  logic [15:0]            j1_io_addr,
   input  logic [15:0]            j1_io_dout,
   input  logic [16*NSLOTS-1:0]   per_dout,
   output logic [NSLOTS-1:0]      cs,
   output logic [15:0]            j1_io_din,
   output logic                   err_irq
);

   logic [7:0]        page;
   logic [NSLOTS-1:0] cs_dec;
   logic              slot_hit;
   logic              stat_hit;
   logic              unmapped;
   logic              any_strobe;
   logic [15:0]       slot_data;
   logic [15:0]       stat_data;
   logic [15:0]       mux_data;

   logic              fault_flag;
   logic              overflow;
   logic              fault_dir;
   logic [15:0]       fault_addr;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
   logic [15:0]       rdata_q;

   logic              unused_in;

   assign page       = j1_io_addr[15:8];
   assign any_strobe = j1_io_rd | j1_io_wr;
   assign unused_in  = ^{j1_io_dout[15:1], j1_io_addr[7:4]};

   // 9-bit compare so BASE_PAGE+k never wraps onto a low page
   always_comb begin
      cs_dec    = '0;
      slot_data = '0;
      for (int k = 0; k < NSLOTS; k++) begin
         if ({1'b0, page} == ({1'b0, BASE_PAGE} + 9'(k))) begin
            cs_dec[k] = 1'b1;
            slot_data = slot_data | per_dout[16*k +: 16];
         end
      end
   end

   assign slot_hit = |cs_dec;
   assign stat_hit = (page == STAT_PAGE);
   assign unmapped = !slot_hit && !stat_hit;
   assign cs       = cs_dec;

   always_comb begin
      stat_data = '0;
      case (j1_io_addr[3:0])
         4'd0:    stat_data = {13'd0, fault_dir, overflow, fault_flag};
         4'd1:    stat_data = fault_addr;
         4'd2:    stat_data = rd_count;
         4'd3:    stat_data = wr_count;
         default: stat_data = '0;
      endcase
   end

   always_comb begin
      mux_data = DEFAULT_DATA;
      if (slot_hit) begin
         mux_data = slot_data;
      end else if (stat_hit) begin
         mux_data = stat_data;
      end
   end

   // Status page writes and counted accesses are mutually exclusive by page
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         fault_flag <= 1'b0;
         overflow   <= 1'b0;
         fault_dir  <= 1'b0;
         fault_addr <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
      end else begin
         if (stat_hit && j1_io_wr) begin
            case (j1_io_addr[3:0])
               4'd0: begin
                  if (j1_io_dout[0]) begin
                     fault_flag <= 1'b0;
                     overflow   <= 1'b0;
                     fault_dir  <= 1'b0;
                  end
               end
               4'd2:    rd_count <= '0;
               4'd3:    wr_count <= '0;
               default: ;
            endcase
         end
         if (!stat_hit) begin
            if (j1_io_rd) begin
               rd_count <= rd_count + 16'd1;
            end
            if (j1_io_wr) begin
               wr_count <= wr_count + 16'd1;
            end
         end
         if (unmapped && any_strobe) begin
            if (!fault_flag) begin
               fault_flag <= 1'b1;
               fault_addr <= j1_io_addr;
               fault_dir  <= j1_io_wr;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         rdata_q <= '0;
      end else if (j1_io_rd) begin
         rdata_q <= mux_data;
      end
   end

   assign j1_io_din = REG_RDATA ? rdata_q : mux_data;
   assign err_irq   = fault_flag;

endmodule

// File: tb/tb_j1_io_fabric.sv
// Scoreboard bench for j1_io_fabric: one combinational and one registered-read
// instance share stimulus; a behavioural model predicts every cycle's outputs.
module tb_j1_io_fabric;

   localparam int NS   = 4;
   localparam int BASE = 'h67;
   localparam int STAT = 'h7F;
   localparam int DFLT = 'h0666;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        rd   = 1'b0;
   logic        wr   = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] dout = '0;
   logic [63:0] pd   = '0;

   logic [3:0]  cs0, cs1;
   logic [15:0] din0, din1;
   logic        irq0, irq1;

   always #5 clk = ~clk;

   j1_io_fabric #(.NSLOTS(NS), .BASE_PAGE(8'h67), .STAT_PAGE(8'h7F),
                  .DEFAULT_DATA(16'h0666), .REG_RDATA(1'b0)) dut_comb (
      .sys_clk_i(clk), .sys_rst_i(rst), .j1_io_rd(rd), .j1_io_wr(wr),
      .j1_io_addr(addr), .j1_io_dout(dout), .per_dout(pd),
      .cs(cs0), .j1_io_din(din0), .err_irq(irq0));

   j1_io_fabric #(.NSLOTS(NS), .BASE_PAGE(8'h67), .STAT_PAGE(8'h7F),
                  .DEFAULT_DATA(16'h0666), .REG_RDATA(1'b1)) dut_reg (
      .sys_clk_i(clk), .sys_rst_i(rst), .j1_io_rd(rd), .j1_io_wr(wr),
      .j1_io_addr(addr), .j1_io_dout(dout), .per_dout(pd),
      .cs(cs1), .j1_io_din(din1), .err_irq(irq1));

   typedef struct {
      logic [3:0]  cs;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        irq;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model state
   int m_flag, m_ovf, m_dir, m_faddr, m_rdc, m_wrc, m_rreg;

   function automatic void model_reset();
      m_flag = 0; m_ovf = 0; m_dir = 0; m_faddr = 0;
      m_rdc = 0; m_wrc = 0; m_rreg = 0;
   endfunction

   function automatic int slot_of(input int pg);
      if (pg >= BASE && pg < BASE + NS) return pg - BASE;
      return -1;
   endfunction

   function automatic int stat_reg(input int r);
      case (r)
         0:       return m_dir * 4 + m_ovf * 2 + m_flag;
         1:       return m_faddr;
         2:       return m_rdc;
         3:       return m_wrc;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One bus cycle: drive, predict outputs for this cycle, then advance the model
   task automatic cyc(input bit r_rst, input bit r_rd, input bit r_wr,
                      input int a, input int d, input logic [63:0] p);
      exp_t e;
      int   pg, s, mux, reg_sel;
      @(posedge clk);
      #1;
      rst  = r_rst;
      rd   = r_rd;
      wr   = r_wr;
      addr = a[15:0];
      dout = d[15:0];
      pd   = p;
      if (r_rst) model_reset();
      pg      = (a >> 8) & 255;
      reg_sel = a & 15;
      s       = slot_of(pg);
      if (s >= 0)         mux = int'(p[16*s +: 16]);
      else if (pg == STAT) mux = stat_reg(reg_sel);
      else                 mux = DFLT;
      e.cs  = (s >= 0) ? 4'(1 << s) : 4'd0;
      e.d0  = 16'(mux);
      e.d1  = 16'(m_rreg);
      e.irq = m_flag[0];
      q.push_back(e);
      if (!r_rst) begin
         if (r_rd) m_rreg = mux;
         if (pg == STAT) begin
            if (r_wr) begin
               if (reg_sel == 0 && (d & 1) != 0) begin
                  m_flag = 0; m_ovf = 0; m_dir = 0;
               end else if (reg_sel == 2) begin
                  m_rdc = 0;
               end else if (reg_sel == 3) begin
                  m_wrc = 0;
               end
            end
         end else begin
            if (r_rd) m_rdc = (m_rdc + 1) % 65536;
            if (r_wr) m_wrc = (m_wrc + 1) % 65536;
            if (s < 0 && (r_rd || r_wr)) begin
               if (m_flag == 0) begin
                  m_flag = 1; m_faddr = a & 'hFFFF; m_dir = r_wr ? 1 : 0;
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
   endtask

   // Monitor: compare every presented cycle against the queued prediction
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("cs_comb", {12'd0, cs0}, {12'd0, e.cs});
         chk("cs_reg",  {12'd0, cs1}, {12'd0, e.cs});
         chk("din_comb", din0, e.d0);
         chk("din_reg",  din1, e.d1);
         chk("irq_comb", {15'd0, irq0}, {15'd0, e.irq});
         chk("irq_reg",  {15'd0, irq1}, {15'd0, e.irq});
      end
   end

   initial begin
      logic [63:0] tp;
      logic [63:0] rp;
      int sel, pg, a, d;
      bit rdv, wrv, rstv;

      model_reset();
      tp = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

      cyc(1, 0, 0, 'h0000, 0, tp);
      cyc(1, 1, 0, 'h6800, 0, tp);
      for (int k = 0; k < NS; k++) cyc(0, 1, 0, (BASE + k) * 256, 0, tp);

      cyc(0, 1, 0, 'h7000, 0, tp);
      cyc(0, 1, 0, 'h7F00, 0, tp);
      cyc(0, 1, 0, 'h7F01, 0, tp);
      cyc(0, 0, 1, 'h7100, 0, tp);
      cyc(0, 1, 0, 'h7F00, 0, tp);
      cyc(0, 1, 0, 'h7F01, 0, tp);
      cyc(0, 0, 1, 'h7F00, 1, tp);
      cyc(0, 1, 0, 'h7F00, 0, tp);
      cyc(0, 0, 0, 'h0000, 0, tp);

      // Registered read: capture slot 1, then hold while peripherals change
      cyc(0, 1, 0, 'h6800, 0, tp);
      for (int k = 0; k < 3; k++) begin
         rp = {$urandom, $urandom};
         cyc(0, 0, 0, 'h6800, 0, rp);
      end
      cyc(0, 1, 0, 'h7F02, 0, tp);
      cyc(0, 1, 0, 'h7F03, 0, tp);
      cyc(0, 1, 1, 'h7000, 0, tp);
      cyc(0, 1, 0, 'h7F00, 0, tp);

      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 5)      pg = BASE + $urandom_range(0, NS - 1);
         else if (sel < 8) pg = STAT;
         else              pg = $urandom_range(0, 255);
         a    = pg * 256 + ((pg == STAT) ? $urandom_range(0, 5) : $urandom_range(0, 255));
         d    = $urandom_range(0, 65535);
         rdv  = ($urandom_range(0, 1) == 1);
         wrv  = (pg == STAT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
         rstv = ($urandom_range(0, 199) == 0);
         rp   = {$urandom, $urandom};
         cyc(rstv, rdv, wrv, a, d, rp);
      end

      // Write counter wrap, then reset in the middle of a read
      cyc(1, 0, 0, 'h0000, 0, tp);
      for (int i = 0; i < 65535; i++) cyc(0, 0, 1, 'h6700, 0, tp);
      cyc(0, 1, 0, 'h7F03, 0, tp);
      cyc(0, 0, 1, 'h6700, 0, tp);
      cyc(0, 1, 0, 'h7F03, 0, tp);
      cyc(0, 1, 0, 'h7000, 0, tp);
      cyc(1, 1, 0, 'h7F02, 0, tp);
      for (int r = 0; r < 4; r++) cyc(0, 1, 0, 'h7F00 + r, 0, tp);
      cyc(0, 0, 0, 'h0000, 0, tp);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
